// File: rtl/axis_axi4_wr_pkg.sv
// Shared AXI4 write-path constants and the command record for the
// stream-to-AXI4 write burst controller.
package axis_axi4_wr_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI bursts may not cross this address boundary
  localparam int unsigned AXI_4KB = 4096;

  // Default-width view of one burst command; the controller packs the same
  // {id, addr, len} order at its own parameterised widths.
  localparam int CMD_ID_W   = 4;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_LEN_W  = 8;

  typedef struct packed {
    logic [CMD_ID_W-1:0]   id;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
  } wr_cmd_t;

endpackage

// File: rtl/axis_wr_sync_fifo.sv
// Generic single-clock show-ahead FIFO. rd_data always presents the head
// entry; writes when full and reads when empty are ignored.
module axis_wr_sync_fifo #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // storage array, no reset needed: pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axis_to_axi4_wr_burst_ctrl.sv
// AXI-Stream to AXI4 write master. Packets are cut into INCR bursts bounded
// by max_len and the 4 KB rule; commands, data and W-lengths are queued so
// AW, W and B progress independently.
module axis_to_axi4_wr_burst_ctrl
  import axis_axi4_wr_pkg::*;
#(
  parameter int DSIZE           = 64,
  parameter int ASIZE           = 32,
  parameter int IDSIZE          = 4,
  parameter int LSIZE           = 8,
  parameter int MAX_BURST       = 16,
  parameter int DATA_DEPTH      = 32,
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     axi_aclk,
  input  logic                                     axi_aresetn,
  input  logic [ASIZE-1:0]                         start_addr,
  input  logic [LSIZE:0]                           max_len,
  input  logic                                     err_clr,
  input  logic [DSIZE-1:0]                         axis_tdata,
  input  logic [DSIZE/8-1:0]                       axis_tkeep,
  input  logic                                     axis_tvalid,
  input  logic                                     axis_tlast,
  output logic                                     axis_tready,
  output logic [IDSIZE-1:0]                        axi_awid,
  output logic [ASIZE-1:0]                         axi_awaddr,
  output logic [LSIZE-1:0]                         axi_awlen,
  output logic [2:0]                               axi_awsize,
  output logic [1:0]                               axi_awburst,
  output logic                                     axi_awvalid,
  input  logic                                     axi_awready,
  output logic [DSIZE-1:0]                         axi_wdata,
  output logic [DSIZE/8-1:0]                       axi_wstrb,
  output logic                                     axi_wlast,
  output logic                                     axi_wvalid,
  input  logic                                     axi_wready,
  input  logic [IDSIZE-1:0]                        axi_bid,
  input  logic [1:0]                               axi_bresp,
  input  logic                                     axi_bvalid,
  output logic                                     axi_bready,
  output logic                                     busy,
  output logic                                     err_sticky,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding
);

  localparam int BYTES = DSIZE / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW    = IDSIZE + ASIZE + LSIZE;

  logic              run;
  logic              in_pkt;
  logic [ASIZE-1:0]  seg_addr, cur_addr;
  logic [LSIZE:0]    beat_cnt, cnt_nxt, limit, len_clamped;
  logic [12:0]       room;
  logic [IDSIZE-1:0] seg_id;
  logic              close, beat_acc, aw_hs, w_hs, b_hs;
  logic              d_full, d_empty, c_full, c_empty, l_full, l_empty;
  logic [CW-1:0]     cmd_in, cmd_out;
  logic [LSIZE-1:0]  l_head, w_beat;
  logic [BYTES+DSIZE-1:0] d_out;

  // bid is not needed: responses are counted, not matched
  logic unused_b;
  assign unused_b = ^{axi_bid, axi_bresp[0]};

  // burst limit for the beat currently offered on the stream
  always_comb begin
    cur_addr = in_pkt ? seg_addr : (start_addr & ~ASIZE'(BYTES - 1));
    room     = (13'(AXI_4KB) - {1'b0, cur_addr[11:0]}) >> BSH;
    if (max_len == '0)                             len_clamped = (LSIZE+1)'(1);
    else if (max_len > (LSIZE+1)'(MAX_BURST))      len_clamped = (LSIZE+1)'(MAX_BURST);
    else                                           len_clamped = max_len;
    limit    = (32'(room) < 32'(len_clamped)) ? (LSIZE+1)'(room) : len_clamped;
    cnt_nxt  = beat_cnt + (LSIZE+1)'(1);
    // >= guards against max_len shrinking mid-burst
    close    = axis_tlast || (cnt_nxt >= limit);
  end

  assign axis_tready = run && !d_full && (!c_full || !close);
  assign beat_acc    = axis_tvalid && axis_tready;
  assign cmd_in      = {seg_id, cur_addr, beat_cnt[LSIZE-1:0]};

  // bready and tready held low until the first clock after reset release
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) run <= 1'b0;
    else              run <= 1'b1;
  end

  // segmenter: track burst address, beat count and id across a packet
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      in_pkt   <= 1'b0;
      seg_addr <= '0;
      beat_cnt <= '0;
      seg_id   <= '0;
    end else if (beat_acc) begin
      in_pkt <= !axis_tlast;
      if (close) begin
        seg_addr <= cur_addr + (ASIZE'(cnt_nxt) << BSH);
        beat_cnt <= '0;
        seg_id   <= seg_id + IDSIZE'(1);
      end else begin
        seg_addr <= cur_addr;
        beat_cnt <= cnt_nxt;
      end
    end
  end

  axis_wr_sync_fifo #(.DSIZE(BYTES + DSIZE), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .wr_en(beat_acc), .wr_data({axis_tkeep, axis_tdata}),
    .rd_en(w_hs), .rd_data(d_out), .full(d_full), .empty(d_empty)
  );

  axis_wr_sync_fifo #(.DSIZE(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .wr_en(beat_acc && close), .wr_data(cmd_in),
    .rd_en(aw_hs), .rd_data(cmd_out), .full(c_full), .empty(c_empty)
  );

  // W lengths enter only after their AW handshake, so W cannot lead AW
  axis_wr_sync_fifo #(.DSIZE(LSIZE), .DEPTH(CMD_DEPTH)) u_len_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .wr_en(aw_hs), .wr_data(axi_awlen),
    .rd_en(w_hs && axi_wlast), .rd_data(l_head), .full(l_full), .empty(l_empty)
  );

  assign {axi_awid, axi_awaddr, axi_awlen} = cmd_out;
  assign axi_awsize  = 3'(BSH);
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awvalid = !c_empty && !l_full && (outstanding < OW'(MAX_OUTSTANDING));
  assign aw_hs       = axi_awvalid && axi_awready;

  assign {axi_wstrb, axi_wdata} = d_out;
  assign axi_wvalid = !d_empty && !l_empty;
  assign axi_wlast  = axi_wvalid && (w_beat == l_head);
  assign w_hs       = axi_wvalid && axi_wready;

  assign axi_bready = run;
  assign b_hs       = axi_bvalid && axi_bready;
  assign busy       = !d_empty || !c_empty || !l_empty || (outstanding != '0);

  // beat index within the current W burst
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)  w_beat <= '0;
    else if (w_hs)     w_beat <= axi_wlast ? '0 : w_beat + LSIZE'(1);
  end

  // AWs issued but not yet answered on B
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)                                   outstanding <= '0;
    else if (aw_hs && !b_hs)                            outstanding <= outstanding + OW'(1);
    else if (b_hs && !aw_hs && outstanding != '0)       outstanding <= outstanding - OW'(1);
  end

  // sticky error on SLVERR/DECERR; a new error beats a same-cycle clear
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)              err_sticky <= 1'b0;
    else if (b_hs && axi_bresp[1]) err_sticky <= 1'b1;
    else if (err_clr)              err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_axis_to_axi4_wr_burst_ctrl.sv
// Directed bench for axis_to_axi4_wr_burst_ctrl with default parameters.
module tb_axis_to_axi4_wr_burst_ctrl;
  import axis_axi4_wr_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] start_addr = '0;
  logic [8:0]  max_len = 9'd16;
  logic        err_clr = 1'b0;
  logic [63:0] axis_tdata = '0;
  logic [7:0]  axis_tkeep = '0;
  logic        axis_tvalid = 1'b0, axis_tlast = 1'b0, axis_tready;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready = 1'b1;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready = 1'b1;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic        busy, err_sticky;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  axis_to_axi4_wr_burst_ctrl dut (
    .axi_aclk(clk), .axi_aresetn(aresetn), .start_addr(start_addr), .max_len(max_len),
    .err_clr(err_clr), .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep),
    .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast), .axis_tready(axis_tready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .busy(busy), .err_sticky(err_sticky), .outstanding(outstanding)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor state, written only by the monitor process
  wr_cmd_t     aw_q[$];
  int          wlast_at[$];
  logic [7:0]  strb_q[$];
  logic [63:0] wdat_q[$];
  int w_cnt = 0, wl_total = 0, aw_total = 0, acc_cnt = 0, w_early = 0;
  logic err_pend = 1'b0, err_next_seen = 1'b0;

  // record handshakes that complete at the following rising edge
  always @(negedge clk) begin
    wr_cmd_t c;
    if (aresetn) begin
      if (axis_tvalid && axis_tready) acc_cnt++;
      if (axi_wvalid && axi_wready) begin
        if (aw_total <= wl_total) w_early++;
        w_cnt++;
        strb_q.push_back(axi_wstrb);
        wdat_q.push_back(axi_wdata);
        if (axi_wlast) begin
          wl_total++;
          wlast_at.push_back(w_cnt);
        end
      end
      if (axi_awvalid && axi_awready) begin
        c.id = axi_awid; c.addr = axi_awaddr; c.len = axi_awlen;
        aw_q.push_back(c);
        aw_total++;
      end
      if (err_pend) begin
        err_next_seen = err_sticky;
        err_pend = 1'b0;
      end
      if (axi_bvalid && axi_bready && axi_bresp[1]) err_pend = 1'b1;
    end
  end

  // B responder: automatic one B per completed burst, or explicit requests
  int b_sent = 0, b_man = 0, b_req_cnt = 0, err_at = -1;
  logic auto_b = 1'b1;
  initial begin
    axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = '0;
    forever begin
      @(posedge clk); #1;
      if (b_man < b_req_cnt || (auto_b && wl_total > b_sent)) begin
        axi_bvalid = 1'b1;
        axi_bresp  = (b_sent == err_at) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_bid    = b_sent[3:0];
        if (b_man < b_req_cnt) b_man++;
        b_sent++;
      end else begin
        axi_bvalid = 1'b0;
        axi_bresp  = AXI_RESP_OKAY;
      end
    end
  end

  // send beats 0..nsend-1 of an n-beat packet; call at posedge+1
  task automatic send_pkt(logic [31:0] addr, int n, int nsend, logic [7:0] last_keep);
    int t;
    start_addr = addr;
    for (int i = 0; i < nsend; i++) begin
      axis_tdata  = {addr, 32'(i)};
      axis_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
      axis_tlast  = (i == n - 1);
      axis_tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!axis_tready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) chk("tready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int t = 0;
    @(negedge clk);
    while (busy && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk({tag, "_idle_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_aw(string tag, int idx, logic [3:0] id, logic [31:0] addr, logic [7:0] len);
    wr_cmd_t c = '0;
    if (idx < aw_q.size()) c = aw_q[idx];
    chk({tag, "_id"}, 64'(c.id), 64'(id));
    chk({tag, "_addr"}, 64'(c.addr), 64'(addr));
    chk({tag, "_len"}, 64'(c.len), 64'(len));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int ab, wb, lb, sb, db, accb;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(axis_tready), 64'd0);
    chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("rst_wlast", 64'(axi_wlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    @(posedge clk); #1 aresetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_bready", 64'(axi_bready), 64'd1);
    chk("rel_tready", 64'(axis_tready), 64'd1);
    chk("awsize", 64'(axi_awsize), 64'd3);
    chk("awburst", 64'(axi_awburst), 64'(AXI_BURST_INCR));
    @(posedge clk); #1;

    // T1: 40 beats at 0x1000, 16-beat bursts
    ab = aw_q.size(); wb = w_cnt; lb = wlast_at.size(); db = wdat_q.size();
    send_pkt(32'h1000, 40, 40, 8'hFF);
    wait_idle("t1");
    chk("t1_naw", 64'(aw_q.size() - ab), 64'd3);
    chk_aw("t1_aw0", ab,     4'd0, 32'h1000, 8'd15);
    chk_aw("t1_aw1", ab + 1, 4'd1, 32'h1080, 8'd15);
    chk_aw("t1_aw2", ab + 2, 4'd2, 32'h1100, 8'd7);
    chk("t1_wlast0", 64'(wlast_at[lb] - wb), 64'd16);
    chk("t1_wlast1", 64'(wlast_at[lb + 1] - wb), 64'd32);
    chk("t1_wlast2", 64'(wlast_at[lb + 2] - wb), 64'd40);
    chk("t1_wdata0", wdat_q[db], {32'h1000, 32'd0});
    chk("t1_wdata39", wdat_q[db + 39], {32'h1000, 32'd39});

    // T2: 4 KB boundary split
    ab = aw_q.size(); wb = w_cnt; lb = wlast_at.size();
    send_pkt(32'h0FE0, 10, 10, 8'hFF);
    wait_idle("t2");
    chk("t2_naw", 64'(aw_q.size() - ab), 64'd2);
    chk_aw("t2_aw0", ab,     4'd3, 32'h0FE0, 8'd3);
    chk_aw("t2_aw1", ab + 1, 4'd4, 32'h1000, 8'd5);
    chk("t2_wlast0", 64'(wlast_at[lb] - wb), 64'd4);
    chk("t2_wlast1", 64'(wlast_at[lb + 1] - wb), 64'd10);

    // T3: AW stalled, command FIFO backpressure
    ab = aw_q.size(); wb = w_cnt; accb = acc_cnt;
    axi_awready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_pkt(32'h2000 + 32'(i) * 32'h40, 1, 1, 8'hFF);
      end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t3_accepted", 64'(acc_cnt - accb), 64'd4);
        chk("t3_tready_low", 64'(axis_tready), 64'd0);
        chk("t3_awvalid", 64'(axi_awvalid), 64'd1);
        chk("t3_no_aw", 64'(aw_q.size() - ab), 64'd0);
        chk("t3_no_w", 64'(w_cnt - wb), 64'd0);
        @(posedge clk); #1 axi_awready = 1'b1;
      end
    join
    wait_idle("t3");
    chk("t3_naw", 64'(aw_q.size() - ab), 64'd6);
    for (int i = 0; i < 6; i++)
      chk_aw($sformatf("t3_aw%0d", i), ab + i, 4'(5 + i), 32'h2000 + 32'(i) * 32'h40, 8'd0);
    chk("t3_w_early", 64'(w_early), 64'd0);

    // T4: outstanding limit, B and AW in the same cycle
    ab = aw_q.size();
    auto_b = 1'b0;
    for (int i = 0; i < 6; i++) send_pkt(32'h3000 + 32'(i) * 32'h40, 1, 1, 8'hFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t4_sat_outst", 64'(outstanding), 64'd4);
    chk("t4_sat_awvalid", 64'(axi_awvalid), 64'd0);
    chk("t4_sat_naw", 64'(aw_q.size() - ab), 64'd4);
    chk("t4_busy", 64'(busy), 64'd1);
    @(posedge clk);
    b_req_cnt += 2;
    @(negedge clk);
    chk("t4_a_outst", 64'(outstanding), 64'd4);
    chk("t4_a_awvalid", 64'(axi_awvalid), 64'd0);
    @(negedge clk);
    chk("t4_b_outst", 64'(outstanding), 64'd3);
    chk("t4_b_awvalid", 64'(axi_awvalid), 64'd1);
    @(negedge clk);
    chk("t4_same_cycle_outst", 64'(outstanding), 64'd3);
    @(negedge clk);
    chk("t4_d_outst", 64'(outstanding), 64'd4);
    chk("t4_d_awvalid", 64'(axi_awvalid), 64'd0);
    @(posedge clk); #1 auto_b = 1'b1;
    wait_idle("t4");
    chk("t4_naw", 64'(aw_q.size() - ab), 64'd6);
    chk_aw("t4_aw4", ab + 4, 4'd15, 32'h3100, 8'd0);
    chk_aw("t4_aw5", ab + 5, 4'd0,  32'h3140, 8'd0);

    // T5: SLVERR on second burst, partial tkeep on last beat
    sb = strb_q.size();
    err_at = b_sent + 1;
    send_pkt(32'h5000, 1, 1, 8'hFF);
    send_pkt(32'h6000, 3, 3, 8'h0F);
    wait_idle("t5");
    chk("t5_err_next", 64'(err_next_seen), 64'd1);
    chk("t5_err", 64'(err_sticky), 64'd1);
    chk("t5_wstrb_full", 64'(strb_q[sb + 1]), 64'hFF);
    chk("t5_wstrb_last", 64'(strb_q[sb + 3]), 64'h0F);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_err_holds", 64'(err_sticky), 64'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", 64'(err_sticky), 64'd0);
    // error and clear together: error wins
    @(posedge clk); #1 auto_b = 1'b0;
    send_pkt(32'h6100, 1, 1, 8'hFF);
    repeat (10) @(posedge clk);
    err_at = b_sent;
    b_req_cnt += 1;
    #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t5_set_wins", 64'(err_sticky), 64'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    err_at = -1;
    auto_b = 1'b1;
    wait_idle("t5b");
    chk("t5_err_final", 64'(err_sticky), 64'd0);

    // T6: reset mid-burst
    send_pkt(32'h3000, 16, 5, 8'hFF);
    @(negedge clk);
    chk("t6_busy_pre", 64'(busy), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_tready", 64'(axis_tready), 64'd0);
    chk("t6_awvalid", 64'(axi_awvalid), 64'd0);
    chk("t6_wvalid", 64'(axi_wvalid), 64'd0);
    chk("t6_wlast", 64'(axi_wlast), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_outst", 64'(outstanding), 64'd0);
    chk("t6_err", 64'(err_sticky), 64'd0);
    @(posedge clk); #1 aresetn = 1'b1;
    repeat (2) @(posedge clk); #1;
    ab = aw_q.size();
    send_pkt(32'h4000, 2, 2, 8'hFF);
    wait_idle("t6");
    chk("t6_naw", 64'(aw_q.size() - ab), 64'd1);
    chk_aw("t6_aw0", ab, 4'd0, 32'h4000, 8'd1);

    // T7: max_len 0 and over-ceiling values
    ab = aw_q.size();
    max_len = 9'd0;
    send_pkt(32'h7000, 2, 2, 8'hFF);
    wait_idle("t7a");
    max_len = 9'd100;
    send_pkt(32'h8000, 20, 20, 8'hFF);
    wait_idle("t7b");
    chk("t7_naw", 64'(aw_q.size() - ab), 64'd4);
    chk_aw("t7_aw0", ab,     4'd1, 32'h7000, 8'd0);
    chk_aw("t7_aw1", ab + 1, 4'd2, 32'h7008, 8'd0);
    chk_aw("t7_aw2", ab + 2, 4'd3, 32'h8000, 8'd15);
    chk_aw("t7_aw3", ab + 3, 4'd4, 32'h8080, 8'd3);
    chk("final_w_early", 64'(w_early), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axis_to_axi4_wr_burst_ctrl.md
Name: axis_to_axi4_wr_burst_ctrl

Overview:
Single-clock, parametrised AXI4 write master fed by an AXI-Stream source; generational successor to the codebase's stream-to-AXI4 write bridges. Each tlast-delimited packet is written starting at a per-packet base address, split into bursts bounded by a runtime max length and by 4 KB boundaries. The block tracks outstanding bursts, collects B responses and passes tkeep straight through to wstrb. It sits between packet producers (DMA, capture paths) and the AXI4 interconnect.

Parameters:
DSIZE, 64, data width in bits (power of two, >= 8); BYTES = DSIZE/8
ASIZE, 32, address width
IDSIZE, 4, AWID width
LSIZE, 8, AWLEN width
MAX_BURST, 16, compile-time ceiling on beats per burst (<= 2**LSIZE)
DATA_DEPTH, 32, data FIFO depth in beats (>= MAX_BURST, power of two)
CMD_DEPTH, 4, command FIFO depth in bursts (power of two)
MAX_OUTSTANDING, 4, maximum AW issued without B received

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
start_addr  in  ASIZE  packet base address, sampled on first beat of each packet
max_len  in  LSIZE+1  beats per burst, 0 treated as 1, clamped to MAX_BURST
err_clr  in  1  clears err_sticky
axis_tdata/tkeep/tvalid/tlast  in  DSIZE/BYTES/1/1  stream input
axis_tready  out  1
axi_awid/awaddr/awlen  out  IDSIZE/ASIZE/LSIZE
axi_awsize/awburst  out  3/2  constant log2(BYTES), INCR
axi_awvalid  out 1;  axi_awready  in 1
axi_wdata/wstrb/wlast/wvalid  out  DSIZE/BYTES/1/1;  axi_wready  in 1
axi_bid/bresp/bvalid  in  IDSIZE/2/1;  axi_bready  out 1
busy  out  1  any data, command or outstanding burst pending
err_sticky  out  1  set on any bresp[1]==1
outstanding  out  clog2(MAX_OUTSTANDING+1)  AWs awaiting B

Behaviour:
- Reset (async, any time, including mid-burst): all FIFOs emptied, counters zero, id=0; outputs axis_tready=0, awvalid=0, wvalid=0, wlast=0, busy=0, err_sticky=0, outstanding=0; axi_bready=1 after reset release.
- Segmenter: first beat of a packet loads seg_addr = start_addr with low log2(BYTES) bits forced to 0. limit = min(clamped max_len, (4096 - seg_addr[11:0])/BYTES). beat_cnt counts accepted beats.
- Burst close when an accepted beat makes beat_cnt==limit or carries tlast: push {id, seg_addr, beat_cnt-1} to command FIFO; id wraps mod 2**IDSIZE; seg_addr += beat_cnt*BYTES; beat_cnt=0; after tlast next beat reloads start_addr.
- axis_tready = data FIFO not full AND (command FIFO not full OR accepted beat would not close the burst). Beat and tkeep are written to the data FIFO on handshake.
- AW: awvalid when command FIFO non-empty AND outstanding < MAX_OUTSTANDING; fields held stable until awready; pop on handshake. Earliest AW: cycle after closing beat.
- W: each AW handshake pushes awlen into a W-length queue (depth CMD_DEPTH). wvalid = data FIFO non-empty AND length queue non-empty. wlast asserted on beat (head length); queue popped on wlast handshake. W never precedes its AW. wstrb = tkeep, not inverted.
- B: outstanding += AW handshake, -= bvalid; simultaneous leaves it unchanged. err_sticky set on bvalid&&bresp[1]; err_clr same cycle as error: set wins.
- Back-to-back bursts sustain one beat/cycle when awready/wready held high.

Decomposition:
- Package axis_axi4_wr_pkg: AXI burst/resp constants (INCR=2'b01, OKAY, SLVERR, DECERR), 4 KB constant, command struct typedef {id, addr, len}.
- Sub-module: one generic sync FIFO (axis_wr_sync_fifo, params DSIZE/DEPTH), instanced for data, command and W-length queues.

Test Plan:
- DSIZE=64, max_len=16, start_addr=0x1000, 40-beat packet -> AW 0x1000/len15, 0x1080/len15, 0x1100/len7; ids 0,1,2; wlast on beats 16,32,40.
- start_addr=0x0FE0, max_len=16, 10 beats -> AW 0x0FE0 len3, then 0x1000 len5; no burst crosses 4 KB.
- awready held low 20 cycles, 6 single-beat packets -> at most CMD_DEPTH commands queued, axis_tready drops, no W before AW, then all drain in order.
- awready=1, bvalid withheld -> outstanding saturates at 4, awvalid low until a B arrives; B and AW same cycle keeps count.
- bresp=2'b10 on second burst -> err_sticky=1 next cycle and stays; err_clr pulse clears; tkeep=0x0F on last beat -> wstrb=0x0F.
- Reset asserted mid-burst (beat 5 of 16) -> all outputs reset values immediately; new packet after release starts id=0 at new start_addr.
